// File: rtl/debug_display_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : debug_display_ctrl_if
// Description : Signal bundle between the debug display controller and its
//               surroundings: step/run controls, breakpoint compare inputs,
//               display source bus and the 7-segment outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface debug_display_ctrl_if #(
   parameter int NUM_SRC    = 8,
   parameter int NUM_DIGITS = 8
);
   localparam int SEL_W = $clog2(NUM_SRC);

   logic                    button;
   logic                    run;
   logic                    bp_en;
   logic [31:0]             bp_addr;
   logic [31:0]             pc;
   logic [SEL_W-1:0]        sel;
   logic                    half;
   logic [32*NUM_SRC-1:0]   src_data;
   logic                    cpu_en;
   logic                    halted;
   logic [NUM_DIGITS-1:0]   LEDSEL;
   logic [7:0]              LEDOUT;

   // Environment side: drives controls and sources, observes outputs
   modport master (
      output button, run, bp_en, bp_addr, pc, sel, half, src_data,
      input  cpu_en, halted, LEDSEL, LEDOUT
   );

   // Controller side
   modport slave (
      input  button, run, bp_en, bp_addr, pc, sel, half, src_data,
      output cpu_en, halted, LEDSEL, LEDOUT
   );
endinterface
`default_nettype wire

// File: rtl/debug_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : debug_display_ctrl
// Description : Single-step / run / breakpoint controller for a CPU clock
//               enable, plus a multiplexed 7-segment display that shows the
//               low PC bits beside a selectable field of a source word.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_display_ctrl #(
   parameter int NUM_SRC    = 8,
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 20000,
   parameter int DB_CYCLES  = 100000
) (
   input  logic                 clk,
   input  logic                 rst,
   debug_display_ctrl_if.slave  bus
);

   localparam int SEL_W   = $clog2(NUM_SRC);
   localparam int H       = NUM_DIGITS / 2;
   localparam int W       = 4 * H;
   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int DW_W    = $clog2(SCAN_DIV);
   localparam int DB_W    = $clog2(DB_CYCLES);

   localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DB_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      HALT  = 2'd0,
      STEP  = 2'd1,
      RUN   = 2'd2,
      BREAK = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Button synchroniser, debouncer and rising-edge step pulse
   // ------------------------------------------------------------------
   logic            sync1, sync2;
   logic            db_level, db_prev;
   logic [DB_W-1:0] db_cnt;
   logic            step_pulse;

   // Two-flop synchroniser, then a level that flips only after a full run
   // of consecutive differing samples; any agreeing sample restarts the run.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         db_level <= 1'b0;
         db_prev  <= 1'b0;
         db_cnt   <= '0;
      end else begin
         sync1   <= bus.button;
         sync2   <= sync1;
         db_prev <= db_level;
         if (sync2 != db_level) begin
            if (db_cnt == DB_MAX) begin
               db_level <= sync2;
               db_cnt   <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign step_pulse = db_level & ~db_prev;

   // ------------------------------------------------------------------
   // Run-control FSM
   // ------------------------------------------------------------------
   state_t state, state_nxt;
   logic   hit;
   logic   cpu_en_c, halted_c;

   assign hit = bus.bp_en & (bus.pc == bus.bp_addr);

   // State register; async reset drops cpu_en without waiting for a clock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= HALT;
      else      state <= state_nxt;
   end

   // Next-state and clock-enable decode; hit gates cpu_en in the same cycle
   always_comb begin
      state_nxt = state;
      cpu_en_c  = 1'b0;
      halted_c  = 1'b1;
      case (state)
         HALT: begin
            if (bus.run && !hit) state_nxt = RUN;
            else if (step_pulse) state_nxt = STEP;
         end
         STEP: begin
            cpu_en_c  = 1'b1;
            halted_c  = 1'b0;
            state_nxt = HALT;
         end
         RUN: begin
            cpu_en_c = ~hit;
            halted_c = 1'b0;
            if (!bus.run) state_nxt = HALT;
            else if (hit) state_nxt = BREAK;
         end
         BREAK: begin
            if (!bus.run)        state_nxt = HALT;
            else if (step_pulse) state_nxt = STEP;
         end
         default: state_nxt = HALT;
      endcase
   end

   assign bus.cpu_en = cpu_en_c;
   assign bus.halted = halted_c;

   // ------------------------------------------------------------------
   // Display source selection and scan
   // ------------------------------------------------------------------
   logic [31:0]           word;
   logic [W-1:0]          field;
   logic [2*W-1:0]        disp_reg, disp_nxt, disp_shift;
   logic [DW_W-1:0]       dwell, dwell_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;
   logic [3:0]            nibble;
   logic [NUM_DIGITS-1:0] ledsel_r;
   logic [7:0]            ledout_r;
   logic                  unused_bits;

   function automatic logic [7:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 8'hC0;
         4'h1: hex_glyph = 8'hF9;
         4'h2: hex_glyph = 8'hA4;
         4'h3: hex_glyph = 8'hB0;
         4'h4: hex_glyph = 8'h99;
         4'h5: hex_glyph = 8'h92;
         4'h6: hex_glyph = 8'h82;
         4'h7: hex_glyph = 8'hF8;
         4'h8: hex_glyph = 8'h80;
         4'h9: hex_glyph = 8'h90;
         4'hA: hex_glyph = 8'h88;
         4'hB: hex_glyph = 8'h83;
         4'hC: hex_glyph = 8'hC6;
         4'hD: hex_glyph = 8'hA1;
         4'hE: hex_glyph = 8'h86;
         default: hex_glyph = 8'h8E;
      endcase
   endfunction

   // Source mux; selections beyond the last source read as zero
   always_comb begin
      word = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (bus.sel == SEL_W'(k)) word = bus.src_data[32*k +: 32];
      end
      field = bus.half ? word[2*W-1:W] : word[W-1:0];
   end

   // Scan sequencing; the shown value is captured only at the frame boundary
   always_comb begin
      dwell_nxt = dwell + 1'b1;
      idx_nxt   = idx;
      disp_nxt  = disp_reg;
      if (dwell == DWELL_MAX) begin
         dwell_nxt = '0;
         if (idx == IDX_MAX) begin
            idx_nxt  = '0;
            disp_nxt = {bus.pc[W-1:0], field};
         end else begin
            idx_nxt = idx + 1'b1;
         end
      end
      disp_shift = disp_nxt >> {idx_nxt, 2'b00};
      nibble     = disp_shift[3:0];
   end

   // Scan state plus registered digit/segment drive, built from next values
   // so the outputs line up with the index they belong to
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dwell    <= '0;
         idx      <= '0;
         disp_reg <= '0;
         ledsel_r <= ~NUM_DIGITS'(1);
         ledout_r <= 8'hC0;
      end else begin
         dwell    <= dwell_nxt;
         idx      <= idx_nxt;
         disp_reg <= disp_nxt;
         ledsel_r <= ~(NUM_DIGITS'(1) << idx_nxt);
         ledout_r <= hex_glyph(nibble);
      end
   end

   assign bus.LEDSEL = ledsel_r;
   assign bus.LEDOUT = ledout_r;

   // Upper PC / word bits are not displayed in every configuration
   assign unused_bits = &{1'b0, bus.pc, word};

endmodule
`default_nettype wire
